// File: rtl/matmul_result_writer_pkg.sv
// Shared definitions for the matmul result writer: default widths, the
// matrix-dimension derivation, FSM state encoding and flat-bus slice helpers.
package matmul_result_writer_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUS_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 8;

    // One result element fills the bus; the array edge is how many operand
    // elements fit in that bus word.
    function automatic int calc_max_dim(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    // LSB of element (row,col) on a row-major flat matrix bus.
    function automatic int elem_lsb(input int row, input int col,
                                    input int max_dim, input int bus_w);
        return (row * max_dim + col) * bus_w;
    endfunction

    // Overflow flags are column-major: flag of (row,col) at row + col*max_dim.
    function automatic int flag_idx(input int row, input int col, input int max_dim);
        return row + col * max_dim;
    endfunction

endpackage

// File: rtl/matmul_result_writer.sv
// Writes a captured matrix-multiply result into the scratchpad, one element
// per accepted write, row-major from base_addr. Write handshake: an element is
// transferred on a rising edge where wr_en_o and wr_ready_i are both high;
// while wr_ready_i is low, wr_en_o/wr_addr_o/wr_data_o hold stable.
module matmul_result_writer
    import matmul_result_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    localparam int MAX_DIM   = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int NELEM     = MAX_DIM * MAX_DIM
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        finish_mul_i,
    input  logic [NELEM*BUS_WIDTH-1:0]  c_matrix_i,
    input  logic [NELEM-1:0]            flags_i,
    input  logic [1:0]                  n_dim_i,
    input  logic [1:0]                  m_dim_i,
    input  logic [ADDR_WIDTH-1:0]       base_addr_i,
    input  logic                        wr_ready_i,
    output logic                        wr_en_o,
    output logic [ADDR_WIDTH-1:0]       wr_addr_o,
    output logic [BUS_WIDTH-1:0]        wr_data_o,
    output logic [NELEM-1:0]            flags_o,
    output logic                        finish_write_o,
    output logic                        busy_o
);

    wr_state_e                    state_q, state_d;
    logic [1:0]                   row_q, row_d;
    logic [1:0]                   col_q, col_d;
    logic [NELEM*BUS_WIDTH-1:0]   c_matrix_q, c_matrix_d;
    logic [NELEM-1:0]             flags_q, flags_d;
    logic [1:0]                   n_dim_q, n_dim_d;
    logic [1:0]                   m_dim_q, m_dim_d;
    logic [ADDR_WIDTH-1:0]        base_q, base_d;

    logic [NELEM-1:0]             active_mask;

    // Active-region mask for the incoming dimensions, in flag bit order.
    always_comb begin
        active_mask = '0;
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                active_mask[flag_idx(r, c, MAX_DIM)] =
                    (r <= int'(n_dim_i)) && (c <= int'(m_dim_i));
            end
        end
    end

    // State and captured-operand registers; reset clears everything at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            c_matrix_q <= '0;
            flags_q    <= '0;
            n_dim_q    <= '0;
            m_dim_q    <= '0;
            base_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            c_matrix_q <= c_matrix_d;
            flags_q    <= flags_d;
            n_dim_q    <= n_dim_d;
            m_dim_q    <= m_dim_d;
            base_q     <= base_d;
        end
    end

    // Next-state: capture in IDLE, walk row-major on accepted writes, then
    // park in DONE until the multiplier withdraws finish_mul_i.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        c_matrix_d = c_matrix_q;
        flags_d    = flags_q;
        n_dim_d    = n_dim_q;
        m_dim_d    = m_dim_q;
        base_d     = base_q;
        case (state_q)
            ST_IDLE: begin
                if (finish_mul_i) begin
                    c_matrix_d = c_matrix_i;
                    flags_d    = flags_i & active_mask;
                    n_dim_d    = n_dim_i;
                    m_dim_d    = m_dim_i;
                    base_d     = base_addr_i;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_ready_i) begin
                    if (col_q == m_dim_q) begin
                        col_d = '0;
                        if (row_q == n_dim_q) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!finish_mul_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write port: address/element mux from the counters, forced to zero
    // whenever no write is requested.
    always_comb begin
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        if (state_q == ST_WRITE) begin
            wr_en_o   = 1'b1;
            // Sum is truncated to ADDR_WIDTH, so addresses wrap past the top.
            wr_addr_o = base_q
                      + ADDR_WIDTH'(row_q) * (ADDR_WIDTH'(m_dim_q) + ADDR_WIDTH'(1))
                      + ADDR_WIDTH'(col_q);
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    if ((int'(row_q) == r) && (int'(col_q) == c)) begin
                        wr_data_o = c_matrix_q[elem_lsb(r, c, MAX_DIM, BUS_WIDTH) +: BUS_WIDTH];
                    end
                end
            end
        end
    end

    assign flags_o        = flags_q;
    assign finish_write_o = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matmul_result_writer.sv
// Directed bench for matmul_result_writer: expected (addr,data) pairs are
// queued when a burst is launched and a negedge monitor pops them on every
// accepted write; the main thread checks timing, flags, hold and reset.
module tb_matmul_result_writer;

  localparam int AW = 8;
  localparam int BW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            finish_mul;
  logic [4*BW-1:0] c_matrix;
  logic [3:0]      flags_in;
  logic [1:0]      n_dim, m_dim;
  logic [AW-1:0]   base_addr;
  logic            wr_ready;
  logic            wr_en_o;
  logic [AW-1:0]   wr_addr_o;
  logic [BW-1:0]   wr_data_o;
  logic [3:0]      flags_o;
  logic            finish_write_o;
  logic            busy_o;

  matmul_result_writer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .finish_mul_i   (finish_mul),
    .c_matrix_i     (c_matrix),
    .flags_i        (flags_in),
    .n_dim_i        (n_dim),
    .m_dim_i        (m_dim),
    .base_addr_i    (base_addr),
    .wr_ready_i     (wr_ready),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .flags_o        (flags_o),
    .finish_write_o (finish_write_o),
    .busy_o         (busy_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  logic [AW+BW-1:0] exp_q[$];
  logic [AW+BW-1:0] mon_e;

  localparam logic [4*BW-1:0] CM_STD = {16'h0044, 16'h0033, 16'h0022, 16'h0011};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [BW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every accepted write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_o && wr_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write", wr_addr_o, wr_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {24'h0, wr_addr_o}, {24'h0, mon_e[AW+BW-1:BW]});
          check("wr_data", {16'h0, wr_data_o}, {16'h0, mon_e[BW-1:0]});
        end
      end else if (!wr_en_o) begin
        check("idle_bus_zero", {8'h0, wr_addr_o, wr_data_o}, 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a job, let it be captured, then scramble the inputs so any use of
  // live inputs instead of captured values shows up in the scoreboard.
  task automatic start_burst(input logic [1:0] n, input logic [1:0] m, input logic [AW-1:0] base,
                             input logic [4*BW-1:0] cm, input logic [3:0] fl);
    @(posedge clk); #1;
    n_dim      = n;
    m_dim      = m;
    base_addr  = base;
    c_matrix   = cm;
    flags_in   = fl;
    finish_mul = 1'b1;
    @(posedge clk); #1;
    n_dim     = 2'($urandom_range(0, 1));
    m_dim     = 2'($urandom_range(0, 1));
    base_addr = 8'($urandom_range(0, 255));
    c_matrix  = {$urandom(), $urandom()};
    flags_in  = 4'($urandom_range(0, 15));
  endtask

  // Wait (bounded) for finish_write, hold finish_mul for 'hold' cycles, then
  // drop it and expect IDLE after the very next edge.
  task automatic end_burst(input string name, input int hold);
    int k;
    k = 0;
    while (finish_write_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_finish_seen"}, {31'h0, finish_write_o}, 32'h1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_finish"}, {31'h0, finish_write_o}, 32'h1);
      check({name, "_hold_no_en"}, {31'h0, wr_en_o}, 32'h0);
    end
    finish_mul = 1'b0;
    @(negedge clk);
    check({name, "_idle_busy"}, {31'h0, busy_o}, 32'h0);
    check({name, "_idle_finish"}, {31'h0, finish_write_o}, 32'h0);
    check({name, "_queue_empty"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int acc0;
    rst        = 1'b1;
    finish_mul = 1'b0;
    c_matrix   = '0;
    flags_in   = '0;
    n_dim      = '0;
    m_dim      = '0;
    base_addr  = '0;
    wr_ready   = 1'b1;
    #2;
    check("rst_wr_en", {31'h0, wr_en_o}, 32'h0);
    check("rst_bus", {8'h0, wr_addr_o, wr_data_o}, 32'h0);
    check("rst_flags", {28'h0, flags_o}, 32'h0);
    check("rst_finish", {31'h0, finish_write_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Base case: 2x2, four back-to-back writes, finish the cycle after.
    acc0 = n_acc;
    push_exp(8'h10, 16'h0011);
    push_exp(8'h11, 16'h0022);
    push_exp(8'h12, 16'h0033);
    push_exp(8'h13, 16'h0044);
    start_burst(2'd1, 2'd1, 8'h10, CM_STD, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("base_wr_en", {31'h0, wr_en_o}, 32'h1);
      check("base_busy", {31'h0, busy_o}, 32'h1);
    end
    @(negedge clk);
    check("base_finish_next", {31'h0, finish_write_o}, 32'h1);
    check("base_en_done", {31'h0, wr_en_o}, 32'h0);
    check("base_flags", {28'h0, flags_o}, 32'hF);
    end_burst("base", 0);
    check("base_count", n_acc - acc0, 32'd4);

    // Single row with flag masking: only (0,0),(0,1) -> bits 0 and 2.
    acc0 = n_acc;
    push_exp(8'h20, 16'h0011);
    push_exp(8'h21, 16'h0022);
    start_burst(2'd0, 2'd1, 8'h20, CM_STD, 4'b1111);
    check("row_flags", {28'h0, flags_o}, 32'h5);
    end_burst("row", 0);
    check("row_count", n_acc - acc0, 32'd2);
    check("row_flags_held", {28'h0, flags_o}, 32'h5);

    // Backpressure on element (0,1) for three cycles.
    acc0 = n_acc;
    push_exp(8'h30, 16'h0011);
    push_exp(8'h31, 16'h0022);
    push_exp(8'h32, 16'h0033);
    push_exp(8'h33, 16'h0044);
    start_burst(2'd1, 2'd1, 8'h30, CM_STD, 4'b0000);
    @(negedge clk);
    @(posedge clk); #1 wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_en", {31'h0, wr_en_o}, 32'h1);
      check("bp_hold_addr", {24'h0, wr_addr_o}, 32'h31);
      check("bp_hold_data", {16'h0, wr_data_o}, 32'h22);
      @(posedge clk);
    end
    #1 wr_ready = 1'b1;
    end_burst("bp", 0);
    check("bp_count", n_acc - acc0, 32'd4);
    check("bp_flags", {28'h0, flags_o}, 32'h0);

    // Address wrap-around.
    acc0 = n_acc;
    push_exp(8'hFE, 16'h00A1);
    push_exp(8'hFF, 16'h00B2);
    push_exp(8'h00, 16'h00C3);
    push_exp(8'h01, 16'h00D4);
    start_burst(2'd1, 2'd1, 8'hFE, {16'h00D4, 16'h00C3, 16'h00B2, 16'h00A1}, 4'b0110);
    end_burst("wrap", 0);
    check("wrap_count", n_acc - acc0, 32'd4);
    check("wrap_flags", {28'h0, flags_o}, 32'h6);

    // Reset after the second write: everything clears at once, no more writes.
    acc0 = n_acc;
    push_exp(8'h40, 16'h0011);
    push_exp(8'h41, 16'h0022);
    start_burst(2'd1, 2'd1, 8'h40, CM_STD, 4'b1001);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    finish_mul = 1'b0;
    #1;
    check("mrst_wr_en", {31'h0, wr_en_o}, 32'h0);
    check("mrst_bus", {8'h0, wr_addr_o, wr_data_o}, 32'h0);
    check("mrst_flags", {28'h0, flags_o}, 32'h0);
    check("mrst_finish", {31'h0, finish_write_o}, 32'h0);
    check("mrst_busy", {31'h0, busy_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_count", n_acc - acc0, 32'd2);
    check("mrst_busy_after", {31'h0, busy_o}, 32'h0);
    check("mrst_queue_empty", exp_q.size(), 32'h0);

    // Held level: finish_mul stays high 10 cycles after DONE -> one burst only.
    acc0 = n_acc;
    push_exp(8'h50, 16'h0011);
    start_burst(2'd0, 2'd0, 8'h50, CM_STD, 4'b1111);
    end_burst("held", 10);
    check("held_count", n_acc - acc0, 32'd1);
    check("held_flags", {28'h0, flags_o}, 32'h1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_result_writer.md
MATMUL_RESULT_WRITER -- requirements
Module: matmul_result_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one operand element.
REQ-002 Parameter BUS_WIDTH, default 16: width of one result element and of the write data bus.
REQ-003 Parameter ADDR_WIDTH, default 8: scratchpad word-address width.
REQ-004 Derived MAX_DIM = BUS_WIDTH/DATA_WIDTH.
REQ-005 Port clk_i, in, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_i, in, 1: reset, asynchronous and active-high.
REQ-007 Port finish_mul_i, in, 1: multiplier result valid; level, held until start is withdrawn.
REQ-008 Port c_matrix_i, in, MAX_DIM*MAX_DIM*BUS_WIDTH: flat result matrix; element (r,c) at bits [(r*MAX_DIM+c+1)*BUS_WIDTH-1 -: BUS_WIDTH].
REQ-009 Port flags_i, in, MAX_DIM*MAX_DIM: PE overflow flags; flag of element (r,c) at bit r+c*MAX_DIM.
REQ-010 Ports n_dim_i and m_dim_i, in, 2 each: result rows-1 and cols-1.
REQ-011 Port base_addr_i, in, ADDR_WIDTH: scratchpad word address of element (0,0).
REQ-012 Port wr_ready_i, in, 1: scratchpad accepts the current write.
REQ-013 Port wr_en_o, out, 1: write request.
REQ-014 Port wr_addr_o, out, ADDR_WIDTH: write word address.
REQ-015 Port wr_data_o, out, BUS_WIDTH: write data.
REQ-016 Port flags_o, out, MAX_DIM*MAX_DIM: latched, masked overflow flags, same bit mapping as flags_i.
REQ-017 Port finish_write_o, out, 1: write-back complete; returned to the multiplier as finish_write_i.
REQ-018 Port busy_o, out, 1: high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, WRITE, DONE.
REQ-020 IDLE: on a rising edge with finish_mul_i=1, capture c_matrix_i, flags_i, n_dim_i, m_dim_i and base_addr_i into internal registers, clear the row/column counters, and go to WRITE.
REQ-021 Captured values alone are used until the next IDLE; input changes during WRITE/DONE have no effect.
REQ-022 WRITE: wr_en_o=1; wr_data_o = captured element (row,col); wr_addr_o = captured base + row*(m_dim+1) + col, computed modulo 2^ADDR_WIDTH (wrap-around).
REQ-023 An element is accepted on a rising edge where wr_en_o=1 and wr_ready_i=1; only then does col increment, or col resets to 0 and row increments when col=m_dim.
REQ-024 While wr_ready_i=0, wr_en_o, wr_addr_o and wr_data_o hold stable.
REQ-025 Write order is row-major; exactly (n_dim+1)*(m_dim+1) writes; elements outside the active region are never written.
REQ-026 Acceptance of element (n_dim,m_dim) moves WRITE to DONE; wr_en_o=0 in DONE.
REQ-027 Latency: first wr_en_o=1 in the cycle after capture; with wr_ready_i=1 throughout, finish_write_o rises one cycle after the last accepted write.
REQ-028 DONE: finish_write_o=1; stay in DONE while finish_mul_i=1; go to IDLE on the first edge with finish_mul_i=0, so there is no repeated burst on a held level.
REQ-029 flags_o is loaded at capture with flags_i ANDed with an active-region mask (row<=n_dim, col<=m_dim); it holds until the next capture or reset.
REQ-030 wr_addr_o and wr_data_o are 0 whenever wr_en_o=0.

Reset
REQ-031 With rst_i=1, immediately and regardless of clk_i: state=IDLE, counters=0, captured registers=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, flags_o=0, finish_write_o=0, busy_o=0.
REQ-032 A reset mid-burst abandons the remaining writes; after release, a new burst starts only on finish_mul_i=1 sampled in IDLE.

Structure
REQ-033 A shared package holds DATA_WIDTH/BUS_WIDTH defaults, the MAX_DIM derivation, the FSM state encoding, and the element-slice index function for flat matrix buses.
REQ-034 This is a single module with no sub-modules; the address/element mux is inline.

Verification
REQ-035 Base case: n=1, m=1, c elements 0x0011/0x0022/0x0033/0x0044 for (0,0),(0,1),(1,0),(1,1), base 0x10, ready=1 -> writes (0x10,0x0011),(0x11,0x0022),(0x12,0x0033),(0x13,0x0044) on 4 consecutive cycles; finish_write_o=1 the next cycle.
REQ-036 Single row: n=0, m=1, base 0x20 -> exactly 2 writes, to 0x20 and 0x21; row 1 is never written.
REQ-037 Backpressure: ready=0 for 3 cycles while element (0,1) is presented -> wr_en_o, wr_addr_o and wr_data_o hold for 3 cycles; the total write count is still 4.
REQ-038 Flag mask: n=0, m=1, flags_i=4'b1111 -> flags_o has only the bits of (0,0) and (0,1) set (bits 0 and 2).
REQ-039 Address wrap: base 0xFE, n=1, m=1 -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-040 Reset and held level: rst_i pulsed after the 2nd write -> all outputs 0 at once and no further writes; separately, finish_mul_i held 10 cycles after DONE -> one burst only, then IDLE when it drops.
